// File: rtl/stim_replay_pkg.sv
// stim_replay_pkg: shared state encoding and default geometry for the stimulus replay buffer.
package stim_replay_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_W = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/stim_replay_mem.sv
// stim_replay_mem: DEPTH x 2W vector store, one write port, registered read port, contents never reset.
module stim_replay_mem
  import stim_replay_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [2*W-1:0] wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [2*W-1:0] rdata
);
  logic [2*W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/stim_replay.sv
// stim_replay: loads X-annotated input vectors, then replays them one per cycle into a netlist.
// Define STIM_REPLAY_LOOP_EN to wrap replay continuously until stop.
module stim_replay
  import stim_replay_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CK,
  input  logic                   RS,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [W-1:0]           ld_data,
  input  logic [W-1:0]           ld_xmask,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  output logic [W-1:0]           pi_val,
  output logic [W-1:0]           pi_x,
  output logic                   pi_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic fetch_q, fetch_d, pi_valid_q, pi_valid_d, blank_q, blank_d;
  logic ld_fire, rd_en, last_rd;
  logic [2*W-1:0] rd_word;
  assign ld_ready = state_q == IDLE && !count_q[AW];
  assign ld_fire = ld_valid && ld_ready;
  assign last_rd = {1'b0, rd_ptr_q} == count_q - 1'b1;
  assign rd_en = state_q == RUN && fetch_q && !stop;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = ld_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d = ld_fire ? count_q + 1'b1 : count_q;
    rd_ptr_d = rd_ptr_q;
    fetch_d = fetch_q;
    pi_valid_d = rd_en;
    blank_d = blank_q && !rd_en;
    if (state_q == RUN) begin
      if (stop) begin
        state_d = DONE;
        fetch_d = 1'b0;
      end else if (fetch_q) begin
`ifdef STIM_REPLAY_LOOP_EN
        rd_ptr_d = last_rd ? '0 : rd_ptr_q + 1'b1;
`else
        rd_ptr_d = rd_ptr_q + 1'b1;
        fetch_d = !last_rd;
`endif
      end else begin
        state_d = DONE;
      end
    end else if (clear) begin
      state_d = IDLE;
      count_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fetch_d = 1'b0;
    end else if (start && |count_d) begin
      state_d = RUN;
      rd_ptr_d = '0;
      fetch_d = 1'b1;
    end
  end
  always_ff @(posedge CK) begin
    if (RS) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      fetch_q <= 1'b0;
      pi_valid_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      fetch_q <= fetch_d;
      pi_valid_q <= pi_valid_d;
      blank_q <= blank_d;
    end
  end
  // X bits are stored already forced to 0 so the read path needs no masking.
  stim_replay_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(CK),
    .we(ld_fire),
    .waddr(wr_ptr_q),
    .wdata({ld_xmask, ld_data & ~ld_xmask}),
    .re(rd_en),
    .raddr(rd_ptr_q),
    .rdata(rd_word)
  );
  assign pi_val = blank_q ? '0 : rd_word[W-1:0];
  assign pi_x = blank_q ? '1 : rd_word[2*W-1:W];
  assign pi_valid = pi_valid_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign count = count_q;
endmodule

// File: tb/tb_stim_replay.sv
// tb_stim_replay: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_stim_replay;
  logic CK = 0, RS = 1, ld_valid = 0, start = 0, stop = 0, clear = 0;
  logic [7:0] ld_data = 0, ld_xmask = 0;
  logic ld_ready, pi_valid, busy, done;
  logic [7:0] pi_val, pi_x;
  logic [4:0] count;
  logic [15:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, n_seen = 0, base;
  stim_replay dut (
    .CK(CK), .RS(RS), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_xmask(ld_xmask), .start(start), .stop(stop), .clear(clear), .pi_val(pi_val),
    .pi_x(pi_x), .pi_valid(pi_valid), .busy(busy), .done(done), .count(count)
  );
  always #5 CK = ~CK;
  task automatic tick();
    @(posedge CK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] d, input logic [7:0] m);
    ld_valid = 1;
    ld_data = d;
    ld_xmask = m;
    tick();
    ld_valid = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask
  always @(negedge CK) begin
    if (pi_valid) begin
      n_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_vector: got val=%0h x=%0h want none", pi_val, pi_x);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({pi_x, pi_val} !== e) begin
          n_bad++;
          $display("FAIL replay_vector: got val=%0h x=%0h want val=%0h x=%0h", pi_val, pi_x, e[7:0], e[15:8]);
        end
      end
    end
  end
  initial begin
    tick();
    tick();
    RS = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_pi_valid", pi_valid, 0);
    chk("rst_pi_val", pi_val, 8'h00);
    chk("rst_pi_x", pi_x, 8'hFF);
    chk("rst_ld_ready", ld_ready, 1);
    pulse_start();
    tick();
    chk("start_empty_busy", busy, 0);
    chk("start_empty_ready", ld_ready, 1);
`ifdef STIM_REPLAY_LOOP_EN
    load(8'h5A, 8'h00);
    load(8'hC3, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'h00, 8'h5A});
      exp_q.push_back({8'h0F, 8'hC0});
    end
    pulse_start();
    chk("loop_first_busy", busy, 1);
    chk("loop_first_pv", pi_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("loop_pv", pi_valid, 1);
    end
    stop = 1;
    tick();
    stop = 0;
    chk("loop_stop_pv", pi_valid, 0);
    chk("loop_stop_done", done, 1);
`else
    load(8'h11, 8'h00);
    load(8'h22, 8'h0F);
    load(8'h33, 8'hFF);
    chk("three_count", count, 3);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({8'h00, 8'h11});
      exp_q.push_back({8'h0F, 8'h20});
      exp_q.push_back({8'hFF, 8'h00});
      pulse_start();
      chk("run_busy", busy, 1);
      chk("run_first_pv", pi_valid, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("run_pv", pi_valid, 1);
      end
      tick();
      chk("end_done", done, 1);
      chk("end_pv", pi_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_hold_val", pi_val, 8'h00);
      chk("end_hold_x", pi_x, 8'hFF);
    end
    clear = 1;
    start = 1;
    tick();
    clear = 0;
    start = 0;
    chk("clear_prio_busy", busy, 0);
    chk("clear_prio_done", done, 0);
    chk("clear_count", count, 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d, m;
      d = 8'(i * 17 + 5);
      m = (i % 3 == 0) ? 8'hF0 : 8'h00;
      load(d, m);
      exp_q.push_back({m, d & ~m});
    end
    chk("full_count", count, 16);
    chk("full_ready", ld_ready, 0);
    load(8'hEE, 8'h00);
    chk("full_17th_count", count, 16);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("full_pv", pi_valid, 1);
    end
    tick();
    chk("full_done", done, 1);
    do_clear();
    for (int i = 1; i <= 5; i++) load(8'(i), 8'h00);
    exp_q.push_back({8'h00, 8'h01});
    exp_q.push_back({8'h00, 8'h02});
    base = n_seen;
    pulse_start();
    tick();
    tick();
    stop = 1;
    tick();
    stop = 0;
    chk("stop_pv", pi_valid, 0);
    chk("stop_done", done, 1);
    chk("stop_hold_val", pi_val, 8'h02);
    tick();
    tick();
    chk("stop_presented", n_seen - base, 2);
    do_clear();
    for (int i = 0; i < 4; i++) load(8'hA0 + 8'(i), 8'h00);
    exp_q.push_back({8'h00, 8'hA0});
    pulse_start();
    clear = 1;
    tick();
    clear = 0;
    chk("clear_in_run_busy", busy, 1);
    chk("clear_in_run_count", count, 4);
    RS = 1;
    tick();
    RS = 0;
    chk("rs_run_busy", busy, 0);
    chk("rs_run_count", count, 0);
    chk("rs_run_pi_x", pi_x, 8'hFF);
    chk("rs_run_pv", pi_valid, 0);
    chk("rs_run_ready", ld_ready, 1);
`endif
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
